// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and the default two-region map (bootrom, main memory) for riscv_mem_router.
package riscv_mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} region_state_t;
    typedef enum logic {PORT_I, PORT_D} port_id_t;
    localparam logic [63:0] DEF_REGION_BASE = {32'h0000_8000, 32'h0000_0000};
    localparam logic [63:0] DEF_REGION_MASK = {32'hFFFF_8000, 32'hFFFF_F000};
endpackage

// File: rtl/riscv_mem_region_port.sv
// riscv_mem_region_port: per-region arbiter, FSM and registered select/address towards one target.
// RISCV_MEM_ROUTER_RR_EN builds a round-robin pointer; otherwise dmem has fixed priority.
module riscv_mem_region_port
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_i,
    input  logic              i_req_d,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [ADDR_W-1:0] i_addr_d,
    input  logic              i_mem_ready,
    output logic              o_select,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_done_i,
    output logic              o_done_d,
    output logic              o_busy_i,
    output logic              o_busy_d
);
    region_state_t     r_state, w_state_nxt;
    port_id_t          w_grant;
    logic              w_both;
    logic              r_select;
    logic [ADDR_W-1:0] r_addr;

    assign w_both = i_req_i & i_req_d;
`ifdef RISCV_MEM_ROUTER_RR_EN
    port_id_t r_ptr;
    assign w_grant = w_both ? r_ptr : (i_req_d ? PORT_D : PORT_I);
    // Only contended grants move the pointer, so a lone requester never steals the next turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= PORT_D;
        else if (r_state == IDLE && w_both)
            r_ptr <= (w_grant == PORT_D) ? PORT_I : PORT_D;
    end
`else
    assign w_grant = i_req_d ? PORT_D : PORT_I;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_req_i | i_req_d) w_state_nxt = (w_grant == PORT_D) ? BUSY_D : BUSY_I;
            default: if (i_mem_ready) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_select <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_select <= w_state_nxt != IDLE;
            if (r_state == IDLE && w_state_nxt != IDLE)
                r_addr <= (w_grant == PORT_D) ? i_addr_d : i_addr_i;
        end
    end

    assign o_select = r_select;
    assign o_addr   = r_addr;
    assign o_busy_i = r_state == BUSY_I;
    assign o_busy_d = r_state == BUSY_D;
    assign o_done_i = o_busy_i & i_mem_ready;
    assign o_done_d = o_busy_d & i_mem_ready;
endmodule

// File: rtl/riscv_mem_router.sv
// riscv_mem_router: registered base/mask router from the hart fetch and load ports to NUM_REGIONS targets.
// Unmapped addresses complete with a fault; RISCV_MEM_ROUTER_RR_EN enables per-region round-robin.
module riscv_mem_router
    import riscv_mem_pkg::*;
#(
    parameter int NUM_REGIONS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hart2imem_addr_valid,
    input  logic [ADDR_W-1:0]             hart2imem_addr,
    output logic                          imem2hart_data_ready,
    output logic [DATA_W-1:0]             imem2hart_data,
    output logic                          imem2hart_fault,
    input  logic                          hart2dmem_addr_valid,
    input  logic [ADDR_W-1:0]             hart2dmem_addr,
    output logic                          dmem2hart_data_ready,
    output logic [DATA_W-1:0]             dmem2hart_data,
    output logic                          dmem2hart_fault,
    output logic [NUM_REGIONS-1:0]        mmu2mem_select,
    output logic [NUM_REGIONS*ADDR_W-1:0] mmu2mem_addr,
    input  logic [NUM_REGIONS-1:0]        mem2mmu_data_ready,
    input  logic [NUM_REGIONS*DATA_W-1:0] mem2mmu_data
);
    logic [1:0]             w_valid, w_elig, w_fault, w_done;
    logic [ADDR_W-1:0]      w_addr [2];
    logic [NUM_REGIONS-1:0] w_hit [2];
    logic [NUM_REGIONS-1:0] w_req_i, w_req_d, w_done_i, w_done_d, w_busy_i, w_busy_d;
    logic [DATA_W-1:0]      w_data [2];
    logic [1:0]             r_ready, r_fault;
    logic [DATA_W-1:0]      r_data [2];

    assign w_valid   = {hart2dmem_addr_valid, hart2imem_addr_valid};
    assign w_addr[0] = hart2imem_addr;
    assign w_addr[1] = hart2dmem_addr;

    // Index 0 is the fetch port, 1 the load port; a port in flight or in its ready cycle is masked.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_hit[p] = '0;
            for (int r = NUM_REGIONS - 1; r >= 0; r--)
                if ((w_addr[p] & REGION_MASK[r*ADDR_W +: ADDR_W]) == REGION_BASE[r*ADDR_W +: ADDR_W])
                    w_hit[p] = NUM_REGIONS'(1) << r;
        end
        w_elig[0] = w_valid[0] & ~|w_busy_i & ~r_ready[0];
        w_elig[1] = w_valid[1] & ~|w_busy_d & ~r_ready[1];
        w_req_i   = {NUM_REGIONS{w_elig[0]}} & w_hit[0];
        w_req_d   = {NUM_REGIONS{w_elig[1]}} & w_hit[1];
        w_fault   = w_elig & {~|w_hit[1], ~|w_hit[0]};
        w_done    = {|w_done_d, |w_done_i};
        w_data[0] = '0;
        w_data[1] = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (w_done_i[r]) w_data[0] = w_data[0] | mem2mmu_data[r*DATA_W +: DATA_W];
            if (w_done_d[r]) w_data[1] = w_data[1] | mem2mmu_data[r*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready   <= '0;
            r_fault   <= '0;
            r_data[0] <= '0;
            r_data[1] <= '0;
        end else begin
            r_ready   <= w_done | w_fault;
            r_fault   <= w_fault;
            r_data[0] <= w_data[0];
            r_data[1] <= w_data[1];
        end
    end

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        riscv_mem_region_port #(.ADDR_W(ADDR_W)) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_req_i    (w_req_i[r]),
            .i_req_d    (w_req_d[r]),
            .i_addr_i   (hart2imem_addr),
            .i_addr_d   (hart2dmem_addr),
            .i_mem_ready(mem2mmu_data_ready[r]),
            .o_select   (mmu2mem_select[r]),
            .o_addr     (mmu2mem_addr[r*ADDR_W +: ADDR_W]),
            .o_done_i   (w_done_i[r]),
            .o_done_d   (w_done_d[r]),
            .o_busy_i   (w_busy_i[r]),
            .o_busy_d   (w_busy_d[r])
        );
    end

    assign imem2hart_data_ready = r_ready[0];
    assign imem2hart_fault      = r_fault[0];
    assign imem2hart_data       = r_data[0];
    assign dmem2hart_data_ready = r_ready[1];
    assign dmem2hart_fault      = r_fault[1];
    assign dmem2hart_data       = r_data[1];
endmodule
